// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, condition-code, state and flag-index definitions for the ALU
// execute sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ORR  = 4'b0011;
  localparam logic [3:0] OP_EOR  = 4'b0100;
  localparam logic [3:0] OP_MOV  = 4'b0101;
  localparam logic [3:0] OP_BIC  = 4'b0110;
  localparam logic [3:0] OP_MVN  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_MOVI = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Opcodes 1001..1100 and 1111 are unassigned and retire as skipped.
  function automatic logic op_legal(input logic [3:0] op);
    return !(((op >= 4'b1001) && (op <= 4'b1100)) || (op == 4'b1111));
  endfunction

  function automatic logic op_writes_rf(input logic [3:0] op);
    return (op <= OP_MVN) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state execute sequencer: accept, condition check, operand fetch into the
// ALU, then write back result and flags. Owns the architectural flags register.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned DW   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [31:0]             instr,
  output logic [$clog2(NREG)-1:0] rf_ra_addr,
  output logic [$clog2(NREG)-1:0] rf_rb_addr,
  input  logic [DW-1:0]           rf_ra_data,
  input  logic [DW-1:0]           rf_rb_data,
  output logic [DW-1:0]           alu_in1,
  output logic [DW-1:0]           alu_in2,
  output logic [3:0]              alu_opcode,
  output logic [2:0]              alu_sr_cont,
  output logic [4:0]              alu_sr_bit,
  output logic                    alu_s,
  output logic [15:0]             alu_imm,
  input  logic [DW-1:0]           alu_out,
  input  logic [3:0]              alu_flags,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_wa,
  output logic [DW-1:0]           rf_wd,
  output logic                    str_en,
  output logic [3:0]              flags_q,
  output logic                    done,
  output logic                    skipped
);

  logic [1:0]    state_q, state_d;
  logic [31:0]   instr_q;
  logic [3:0]    flags_d;
  logic [DW-1:0] alu_in1_q, alu_in2_q;
  logic [3:0]    alu_opcode_q;
  logic [2:0]    alu_sr_cont_q;
  logic [4:0]    alu_sr_bit_q;
  logic          alu_s_q;
  logic [15:0]   alu_imm_q;

  logic [3:0] op;
  logic       cond_pass;
  logic       go;
  logic       alu_ld;
  logic       in_wb;
  logic       is_str;
  logic       writes_rf;

  assign op = instr_q[27:24];

  cond_eval u_cond_eval (
    .cond_i  (instr_q[31:28]),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  assign go        = cond_pass && op_legal(op);
  assign alu_ld    = (state_q == ST_DECODE) && go;
  assign in_wb     = (state_q == ST_WB);
  assign is_str    = (op == OP_STR);
  assign writes_rf = op_writes_rf(op);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = go ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign flags_d = (in_wb && alu_s_q) ? alu_flags : flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if ((state_q == ST_IDLE) && instr_valid) instr_q <= instr;
    end
  end

  // Operands are captured on leaving DECODE so the combinational ALU settles
  // through EXEC and its result is stable for WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_opcode_q  <= '0;
      alu_sr_cont_q <= '0;
      alu_sr_bit_q  <= '0;
      alu_s_q       <= 1'b0;
      alu_imm_q     <= '0;
    end else if (alu_ld) begin
      alu_in1_q     <= rf_ra_data;
      alu_in2_q     <= rf_rb_data;
      alu_opcode_q  <= (op == OP_CMP) ? OP_SUB : op;
      alu_s_q       <= (op == OP_CMP) ? 1'b1 : instr_q[23];
      alu_sr_cont_q <= instr_q[10:8];
      alu_sr_bit_q  <= instr_q[7:3];
      alu_imm_q     <= instr_q[15:0];
    end
  end

  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_sr_cont = alu_sr_cont_q;
  assign alu_sr_bit  = alu_sr_bit_q;
  assign alu_s       = alu_s_q;
  assign alu_imm     = alu_imm_q;

  assign rf_ra_addr = instr_q[18:15];
  assign rf_rb_addr = instr_q[14:11];

  assign instr_ready = (state_q == ST_IDLE);
  assign rf_we       = in_wb && writes_rf;
  assign str_en      = in_wb && is_str;
  assign rf_wa       = rf_we ? instr_q[22:19] : '0;
  assign rf_wd       = (in_wb && (writes_rf || is_str)) ? alu_out : '0;
  assign skipped     = (state_q == ST_DECODE) && !go;
  assign done        = in_wb || skipped;

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute sequencer for the 32-bit ALU. It accepts one instruction word per valid/ready handshake and evaluates the 4-bit condition field against the architectural {N,Z,C,V} flags register, which this block owns. It then reads operands from the register file, drives the ALU control inputs, and writes back the result and flags. It sits between instruction fetch and the ALU/register-file pair and implements CMP and conditional execution on top of the ALU.

Parameters:
NREG, 16, number of architectural registers; register address width is log2(NREG) = 4.
DW, 32, datapath width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr_valid  in  1  instruction word present.
instr_ready  out  1  block can accept an instruction (IDLE only).
instr  in  32  instruction: [31:28] cond, [27:24] op, [23] S, [22:19] Rd, [18:15] Rn, [14:11] Rm, [10:8] sr_cont, [7:3] sr_bit, [15:0] imm (MOVI only).
rf_ra_addr  out  4  register-file read port A address (Rn).
rf_rb_addr  out  4  register-file read port B address (Rm).
rf_ra_data  in  DW  combinational read data, port A.
rf_rb_data  in  DW  combinational read data, port B.
alu_in1  out  DW  registered ALU operand 1.
alu_in2  out  DW  registered ALU operand 2.
alu_opcode  out  4  ALU opcode.
alu_sr_cont  out  3  shift/rotate control.
alu_sr_bit  out  5  shift amount.
alu_s  out  1  flag-enable to ALU.
alu_imm  out  16  immediate to ALU.
alu_out  in  DW  ALU result.
alu_flags  in  4  ALU {N,Z,C,V}.
rf_we  out  1  register-file write enable (1-cycle pulse).
rf_wa  out  4  write address.
rf_wd  out  DW  write data.
str_en  out  1  1-cycle pulse: STR executed; rf_wd carries the ALU result.
flags_q  out  4  architectural {N,Z,C,V}.
done  out  1  1-cycle pulse: instruction retired.
skipped  out  1  qualifies done: condition failed or op illegal; no architectural effect.

Behaviour:
- Reset values: all outputs 0 except instr_ready = 1. State = IDLE, flags_q = 0.
- Reset asserted mid-instruction aborts it. No rf_we, str_en or done is issued afterwards.
- IDLE: instr_ready = 1. On instr_valid, latch instr and go to DECODE.
- DECODE: evaluate cond against flags_q.
  - Condition false, or op in {1001..1100, 1111}: pulse done with skipped = 1, return to IDLE. Latency from accept = 1 cycle.
  - Otherwise drive rf_ra_addr = Rn and rf_rb_addr = Rm, then go to EXEC.
- EXEC: register alu_in1 = rf_ra_data, alu_in2 = rf_rb_data, alu_opcode, sr_cont, sr_bit, imm and alu_s.
  - CMP (op 1000) drives alu_opcode = 0001 and alu_s = 1. All other ops use alu_opcode = op and alu_s = S.
  - Go to WB.
- WB: the ALU is combinational, so alu_out and alu_flags are valid this cycle.
  - rf_we = 1, rf_wa = Rd, rf_wd = alu_out, for ops 0000–0111 and 1101.
  - CMP: no rf_we.
  - STR (1110): no rf_we; pulse str_en with rf_wd = alu_out.
  - flags_q <= alu_flags when alu_s = 1.
  - Pulse done with skipped = 0, return to IDLE. Latency from accept = 3 cycles; throughput 1 instruction per 4 cycles.
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Back-to-back flag dependence: the next instruction's DECODE sees flags_q as updated by the previous WB.
- alu_* outputs hold their values outside EXEC/WB.
- rf_we and str_en are never high together.

Decomposition:
- Package alu_ctrl_pkg: opcode constants (OP_ADD … OP_STR, OP_CMP = 4'b1000), condition-code constants, state encoding {IDLE, DECODE, EXEC, WB}, flag bit indices.
- Sub-module cond_eval: combinational (cond[3:0], flags[3:0]) -> pass.

Test Plan:
- Reset: rst_n low for 2 cycles -> instr_ready = 1, flags_q = 0, no done; reset asserted in EXEC -> no rf_we, returns to IDLE.
- ADD with S = 1, R1 = 0xFFFFFFFF, R2 = 1, Rd = 3 -> done 3 cycles after accept; rf_we, rf_wa = 3, rf_wd = 0; flags_q = 4'b0110.
- CMP R4, R5 with both = 7 -> alu_opcode = 0001, no rf_we, flags_q.Z = 1; following ADDNE (cond 0001) -> done with skipped = 1 one cycle after accept, no rf_we.
- MOVI Rd = 2, imm = 0x1234, cond AL -> rf_wd = 0x00001234, flags_q unchanged (S = 0).
- Illegal op 1010 and cond NV -> done with skipped = 1, no rf_we or str_en; instr_valid held high -> instr_ready low outside IDLE, next instruction accepted only in IDLE.
- ADD with sr_cont = 010, sr_bit = 4 -> alu_sr_cont/alu_sr_bit forwarded in EXEC, rf_wd equals the ALU result for R1 + (R2 << 4).
